// File: rtl/rs_dispatcher.sv
// Issue controller: picks a free reservation station of the instruction's class (round-robin),
// allocates a reorder-buffer slot, drives the CDB_inst triple and sequences the RS flush.
module rs_dispatcher #(
    parameter int FU_NUM       = 4,
    parameter int FU_INDEX     = 3,
    parameter int RB_INDEX     = 3,
    parameter int WORD_SIZE    = 32,
    parameter int OPCODE_WIDTH = 4,
    parameter logic [2*FU_NUM-1:0]            FU_CLASS_MAP = {2'd2, 2'd1, 2'd0, 2'd0},
    parameter logic [2*(2**OPCODE_WIDTH)-1:0] OP_CLASS_MAP = '0,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WORD_SIZE-1:0] in_inst,
    output logic                 in_ready,
    input  logic                 rb_free,
    input  logic [RB_INDEX-1:0]  rb_free_index,
    output logic                 rb_alloc,
    input  logic [FU_NUM-1:0]    busy_in,
    output logic [FU_INDEX-1:0]  fu_out,
    output logic [RB_INDEX-1:0]  RB_index_out,
    output logic [WORD_SIZE-1:0] inst_out,
    input  logic                 flush,
    output logic [FU_NUM-1:0]    reset_bus_out,
    output logic                 illegal_op,
    output logic                 dbg_state_out
);

    localparam logic [FU_INDEX-1:0] FU_IDLE = {FU_INDEX{1'b1}};
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

    typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [FU_INDEX-1:0]  r_fu;
    logic [RB_INDEX-1:0]  r_rb_idx;
    logic [WORD_SIZE-1:0] r_inst;
    logic [FU_NUM-1:0]    r_rst_bus;
    logic                 r_illegal;
    logic [FU_NUM-1:0]    r_recent;
    logic [FU_INDEX-1:0]  r_rr_ptr [4];

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [1:0]              w_cls;
    logic [FU_NUM-1:0]       w_cand;
    logic                    w_found;
    logic [FU_INDEX-1:0]     w_win;
    logic [FU_INDEX-1:0]     w_next_ptr;
    logic [FU_NUM-1:0]       w_onehot;
    logic                    w_accept;
    logic                    w_illegal;
    int                      w_ptr_int;
    int                      w_nxt;

    always_comb begin
        w_opcode   = in_inst[WORD_SIZE-1 -: OPCODE_WIDTH];
        w_cls      = 2'd0;
        w_cand     = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_next_ptr = '0;
        w_onehot   = '0;
        w_nxt      = 0;
        for (int o = 0; o < 2**OPCODE_WIDTH; o++) begin
            if (w_opcode == o[OPCODE_WIDTH-1:0]) w_cls = OP_CLASS_MAP[2*o +: 2];
        end
        // recent masks the FU issued last cycle, whose busy_out has not risen yet
        for (int i = 0; i < FU_NUM; i++) begin
            w_cand[i] = (FU_CLASS_MAP[2*i +: 2] == w_cls) && !busy_in[i] && !r_recent[i];
        end
        w_ptr_int = int'(r_rr_ptr[w_cls]);
        for (int k = 0; k < FU_NUM; k++) begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (!w_found && w_cand[i] && ((w_ptr_int + k) % FU_NUM == i)) begin
                    w_found     = 1'b1;
                    w_win       = i[FU_INDEX-1:0];
                    w_nxt       = (i + 1) % FU_NUM;
                    w_next_ptr  = w_nxt[FU_INDEX-1:0];
                    w_onehot    = '0;
                    w_onehot[i] = 1'b1;
                end
            end
        end
        w_accept  = (r_state == S_RUN) && in_valid && rb_free && w_found && (w_cls != 2'd3) && !flush;
        w_illegal = (r_state == S_RUN) && in_valid && (w_cls == 2'd3) && !flush;
        in_ready  = w_accept || w_illegal;
        rb_alloc  = w_accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_fu      <= FU_IDLE;
            r_rb_idx  <= '0;
            r_inst    <= '0;
            r_rst_bus <= '0;
            r_illegal <= 1'b0;
            r_recent  <= '0;
            for (int c = 0; c < 4; c++) r_rr_ptr[c] <= '0;
        end else begin
            r_fu      <= FU_IDLE;
            r_recent  <= '0;
            r_illegal <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        r_state   <= S_FLUSH;
                        r_cnt     <= FLUSH_LOAD;
                        r_rst_bus <= '1;
                    end else if (w_accept) begin
                        r_fu            <= w_win;
                        r_rb_idx        <= rb_free_index;
                        r_inst          <= in_inst;
                        r_recent        <= w_onehot;
                        r_rr_ptr[w_cls] <= w_next_ptr;
                    end else if (w_illegal) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    // a held flush keeps reloading, stretching the reset_bus pulse
                    if (flush) begin
                        r_cnt <= FLUSH_LOAD;
                    end else if (r_cnt <= CNT_W'(1)) begin
                        r_state   <= S_RUN;
                        r_cnt     <= '0;
                        r_rst_bus <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign fu_out        = r_fu;
    assign RB_index_out  = r_rb_idx;
    assign inst_out      = r_inst;
    assign reset_bus_out = r_rst_bus;
    assign illegal_op    = r_illegal;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_rs_dispatcher.sv
// Directed bench for rs_dispatcher: issue triples go through an expected queue and are
// popped when the dispatcher drives the CDB; handshake and flush outputs are checked per step.
module tb_rs_dispatcher;

    localparam int FU_NUM    = 4;
    localparam int FU_INDEX  = 3;
    localparam int RB_INDEX  = 3;
    localparam int WORD_SIZE = 32;
    localparam logic [FU_INDEX-1:0] FU_IDLE = '1;
    // opcode 1 -> class 1, opcode 15 -> class 3 (no FU), everything else class 0
    localparam logic [31:0] OP_MAP = 32'hC000_0004;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic [WORD_SIZE-1:0] in_inst;
    logic                 in_ready;
    logic                 rb_free;
    logic [RB_INDEX-1:0]  rb_free_index;
    logic                 rb_alloc;
    logic [FU_NUM-1:0]    busy_in;
    logic [FU_INDEX-1:0]  fu_out;
    logic [RB_INDEX-1:0]  RB_index_out;
    logic [WORD_SIZE-1:0] inst_out;
    logic                 flush;
    logic [FU_NUM-1:0]    reset_bus_out;
    logic                 illegal_op;
    logic                 dbg_state_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [37:0] exp_q[$];

    rs_dispatcher #(
        .FU_NUM(FU_NUM), .FU_INDEX(FU_INDEX), .RB_INDEX(RB_INDEX), .WORD_SIZE(WORD_SIZE),
        .OPCODE_WIDTH(4), .FU_CLASS_MAP(8'b10_01_00_00), .OP_CLASS_MAP(OP_MAP),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
        .rb_free(rb_free), .rb_free_index(rb_free_index), .rb_alloc(rb_alloc),
        .busy_in(busy_in), .fu_out(fu_out), .RB_index_out(RB_index_out), .inst_out(inst_out),
        .flush(flush), .reset_bus_out(reset_bus_out), .illegal_op(illegal_op),
        .dbg_state_out(dbg_state_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WORD_SIZE-1:0] inst, input logic rbf,
                         input logic [RB_INDEX-1:0] rbi, input logic [FU_NUM-1:0] busy,
                         input logic fl);
        in_valid      = v;
        in_inst       = inst;
        rb_free       = rbf;
        rb_free_index = rbi;
        busy_in       = busy;
        flush         = fl;
    endtask

    task automatic check_out(input string tag);
        logic [37:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_issue"}, 64'({fu_out, RB_index_out, inst_out}), 64'(e));
        end else begin
            chk({tag, "_idle"}, 64'(fu_out), 64'(FU_IDLE));
        end
    endtask

    // Inputs are driven on the falling edge; handshake is checked 1 ns later, CDB on the next falling edge.
    task automatic step(input string tag, input logic exp_rdy, input logic exp_alloc,
                        input logic [FU_INDEX-1:0] exp_fu);
        #1;
        chk({tag, "_ready"}, 64'(in_ready), 64'(exp_rdy));
        chk({tag, "_alloc"}, 64'(rb_alloc), 64'(exp_alloc));
        if (exp_alloc) exp_q.push_back({exp_fu, rb_free_index, in_inst});
        @(negedge clk);
        check_out(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_fu", 64'(fu_out), 64'(FU_IDLE));
        chk("rst_rb", 64'(RB_index_out), 64'(0));
        chk("rst_inst", 64'(inst_out), 64'(0));
        chk("rst_bus", 64'(reset_bus_out), 64'(0));
        chk("rst_illegal", 64'(illegal_op), 64'(0));
        chk("rst_state", 64'(dbg_state_out), 64'(0));
        reset = 1'b0;

        // back-to-back class-0 issue; FU0 reused only once its busy has dropped
        drive(1'b1, 32'h0000_0A01, 1'b1, 3'd1, 4'b0000, 1'b0);
        step("t1a", 1'b1, 1'b1, 3'd0);
        drive(1'b1, 32'h0000_0A02, 1'b1, 3'd2, 4'b0000, 1'b0);
        step("t1b", 1'b1, 1'b1, 3'd1);
        drive(1'b1, 32'h0000_0A03, 1'b1, 3'd3, 4'b0001, 1'b0);
        step("t1c", 1'b0, 1'b0, 3'd0);
        chk("t1c_hold_rb", 64'(RB_index_out), 64'(2));
        chk("t1c_hold_inst", 64'(inst_out), 64'(32'h0000_0A02));
        drive(1'b1, 32'h0000_0A03, 1'b1, 3'd3, 4'b0010, 1'b0);
        step("t1d", 1'b1, 1'b1, 3'd0);

        // no ROB slot stalls; slot 5 then goes to FU1 (FU0 busy)
        drive(1'b1, 32'h0000_0B00, 1'b0, 3'd0, 4'b0001, 1'b0);
        step("t2a", 1'b0, 1'b0, 3'd0);
        drive(1'b1, 32'h0000_0B00, 1'b1, 3'd5, 4'b0001, 1'b0);
        step("t2b", 1'b1, 1'b1, 3'd1);
        drive(1'b0, 32'h0000_0B00, 1'b1, 3'd5, 4'b0000, 1'b0);
        step("t2c", 1'b0, 1'b0, 3'd0);

        // class-3 opcode is consumed and dropped
        drive(1'b1, 32'hF000_0000, 1'b1, 3'd6, 4'b0000, 1'b0);
        step("t3a", 1'b1, 1'b0, 3'd0);
        chk("t3a_illegal", 64'(illegal_op), 64'(1));
        chk("t3a_hold_rb", 64'(RB_index_out), 64'(5));
        drive(1'b0, 32'h0000_0000, 1'b1, 3'd6, 4'b0000, 1'b0);
        step("t3b", 1'b0, 1'b0, 3'd0);
        chk("t3b_illegal", 64'(illegal_op), 64'(0));

        // flush beats an eligible instruction; reset_bus high for exactly 2 cycles
        drive(1'b1, 32'h0000_0C00, 1'b1, 3'd4, 4'b0000, 1'b1);
        step("t4a", 1'b0, 1'b0, 3'd0);
        chk("t4a_bus", 64'(reset_bus_out), 64'(4'b1111));
        chk("t4a_state", 64'(dbg_state_out), 64'(1));
        drive(1'b1, 32'h0000_0C00, 1'b1, 3'd4, 4'b0000, 1'b0);
        step("t4b", 1'b0, 1'b0, 3'd0);
        chk("t4b_bus", 64'(reset_bus_out), 64'(4'b1111));
        step("t4c", 1'b0, 1'b0, 3'd0);
        chk("t4c_bus", 64'(reset_bus_out), 64'(4'b0000));
        chk("t4c_state", 64'(dbg_state_out), 64'(0));
        // class-0 pointer was 2 before the flush: scan 2,3,0 lands on FU0
        step("t4d", 1'b1, 1'b1, 3'd0);

        // class-0 head stalls with FU0/FU1 busy even though class-1 FU2 is free
        drive(1'b1, 32'h0000_0D00, 1'b1, 3'd7, 4'b0011, 1'b0);
        step("t5a", 1'b0, 1'b0, 3'd0);
        drive(1'b1, 32'h1000_0000, 1'b1, 3'd7, 4'b0011, 1'b0);
        step("t5b", 1'b1, 1'b1, 3'd2);

        // reset during the first flush cycle clears reset_bus and pointers
        drive(1'b0, 32'h0000_0000, 1'b1, 3'd0, 4'b0000, 1'b1);
        step("t6a", 1'b0, 1'b0, 3'd0);
        chk("t6a_bus", 64'(reset_bus_out), 64'(4'b1111));
        reset = 1'b1;
        drive(1'b0, 32'h0000_0000, 1'b1, 3'd0, 4'b0000, 1'b0);
        step("t6b", 1'b0, 1'b0, 3'd0);
        chk("t6b_bus", 64'(reset_bus_out), 64'(4'b0000));
        chk("t6b_state", 64'(dbg_state_out), 64'(0));
        reset = 1'b0;
        drive(1'b1, 32'h0000_0E00, 1'b1, 3'd2, 4'b0000, 1'b0);
        step("t6c", 1'b1, 1'b1, 3'd0);

        chk("q_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
